// File: rtl/onehot_encoder_32_5_pkg.sv
// Shared types and widths for the one-hot / multi-hot index encoder.
//   MASK_W : width of the captured bit vector
//   IDX_W  : width of an emitted binary index
//   CNT_W  : width of the remaining-index counter (0..MASK_W)
//   state_e: controller states (IDLE, EMIT)
//   popcount(): number of set bits in a mask
package onehot_encoder_32_5_pkg;

  localparam int unsigned MASK_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Number of set bits in v; used to seed the remaining-index counter on load.
  function automatic logic [CNT_W-1:0] popcount(input logic [MASK_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/onehot_encoder_32_5_priority_enc.sv
// Combinational priority encoder over a 32-bit vector.
//   ORDER : 0 selects the lowest set bit, 1 selects the highest set bit
//   vec   : input vector
//   idx   : binary index of the selected bit (0 when vec is empty)
//   any   : high when at least one bit of vec is set
module priority_enc_32_5
  import onehot_encoder_32_5_pkg::*;
#(
  parameter int unsigned ORDER = 0
) (
  input  logic [MASK_W-1:0] vec,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  // Later loop iterations win, so the scan direction sets the priority.
  always_comb begin
    idx = '0;
    any = |vec;
    if (ORDER == 0) begin
      for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(MASK_W); i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_encoder_32_5.sv
// Captures a 32-bit mask and emits the index of each set bit once, one per
// accepted valid/ready handshake, in lowest-first or highest-first order.
//   clock, ctrl_reset : clock and asynchronous active-high reset
//   load, mask_in     : capture request and mask (taken only while idle)
//   busy              : a captured mask is being emitted
//   idx_valid/ready   : handshake for idx_out
//   idx_out           : index of the currently selected pending bit
//   count             : indices not yet accepted
//   done              : one-cycle pulse after the last accept or an empty load
module onehot_encoder_32_5
  import onehot_encoder_32_5_pkg::*;
#(
  parameter int unsigned ORDER = 0
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              load,
  input  logic [MASK_W-1:0] mask_in,
  output logic              busy,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IDX_W-1:0]  idx_out,
  output logic [CNT_W-1:0]  count,
  output logic              done
);

  state_e            state;
  state_e            state_next;
  logic [MASK_W-1:0] pending;
  logic [CNT_W-1:0]  cnt;
  logic              done_r;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_any;
  logic [MASK_W-1:0] sel_mask;
  logic              load_take;
  logic              accept;
  logic              last;

  priority_enc_32_5 #(
    .ORDER(ORDER)
  ) u_enc (
    .vec(pending),
    .idx(sel_idx),
    .any(sel_any)
  );

  assign load_take = (state == IDLE) && load;
  assign accept    = (state == EMIT) && sel_any && idx_ready;
  assign last      = (cnt == CNT_W'(1));
  assign sel_mask  = MASK_W'(1) << sel_idx;

  // State register.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= state_next;
  end

  // Next state: an empty mask never enters EMIT; leave on the final accept.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load && (mask_in != '0)) state_next = EMIT;
      EMIT:    if (accept && last)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs come from registers or from pending through the encoder only.
  always_comb begin
    busy      = (state == EMIT);
    idx_valid = (state == EMIT) && sel_any;
    idx_out   = sel_idx;
    count     = cnt;
    done      = done_r;
  end

  // Pending mask, remaining count and done pulse.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      pending <= '0;
      cnt     <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load_take) begin
        pending <= mask_in;
        cnt     <= popcount(mask_in);
        done_r  <= (mask_in == '0);
      end else if (accept) begin
        pending <= pending & ~sel_mask;
        cnt     <= cnt - CNT_W'(1);
        done_r  <= last;
      end
    end
  end

endmodule
